// File: rtl/piano_pkg.sv
// Shared envelope types, default step constants and width helper for the envelope mixer.
// The saturating output option is selected by ENVELOPE_MIXER_SATURATE_EN.
package piano_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    localparam int DEFAULT_SHIFT_MAX    = 8;
    localparam int DEFAULT_ATTACK_STEP  = 4;
    localparam int DEFAULT_RELEASE_STEP = 8;

    // Bits needed to hold an attenuation shift in 0..shift_max.
    function automatic int shift_w(input int shift_max);
        return $clog2(shift_max + 1);
    endfunction

endpackage

// File: rtl/voice_envelope.sv
// One voice: gate edge detector, attack/sustain/release FSM with step counter,
// and the registered stage-1 attenuated contribution.
module voice_envelope
    import piano_pkg::*;
#(
    parameter int SAMPLE_W     = 8,
    parameter int SHIFT_MAX    = DEFAULT_SHIFT_MAX,
    parameter int ATTACK_STEP  = DEFAULT_ATTACK_STEP,
    parameter int RELEASE_STEP = DEFAULT_RELEASE_STEP
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                gate_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic [SAMPLE_W-1:0] contrib_o,
    output logic                active_o
);

    localparam int SHIFT_W  = shift_w(SHIFT_MAX);
    localparam int MAX_STEP = (ATTACK_STEP > RELEASE_STEP) ? ATTACK_STEP : RELEASE_STEP;
    localparam int CNT_W    = (MAX_STEP > 1) ? $clog2(MAX_STEP) : 1;

    localparam logic [SHIFT_W-1:0] SHIFT_FULL   = SHIFT_W'(SHIFT_MAX);
    localparam logic [CNT_W-1:0]   ATTACK_LAST  = CNT_W'(ATTACK_STEP - 1);
    localparam logic [CNT_W-1:0]   RELEASE_LAST = CNT_W'(RELEASE_STEP - 1);

    env_state_t          state_q, state_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                gate_q;
    logic [SAMPLE_W-1:0] contrib_q, contrib_d;
    logic                active_q, active_d;
    logic                rise, fall;

    assign rise = gate_i & ~gate_q;
    assign fall = ~gate_i & gate_q;

    // NOTE: every state register updates with <= so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= SHIFT_FULL;
            cnt_q     <= '0;
            gate_q    <= 1'b0;
            contrib_q <= '0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            gate_q    <= gate_i;
            contrib_q <= contrib_d;
            active_q  <= active_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        contrib_d = (state_q == IDLE) ? '0 : (sample_i >> shift_q);
        active_d  = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = ATTACK;
                    shift_d = SHIFT_FULL;
                end
            end
            ATTACK: begin
                // A gate edge outranks a step landing on the same clock.
                if (fall) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == ATTACK_LAST) begin
                    cnt_d   = '0;
                    shift_d = (shift_q == '0) ? '0 : shift_q - 1'b1;
                    if (shift_d == '0) state_d = SUSTAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SUSTAIN: begin
                cnt_d = '0;
                if (fall) state_d = RELEASE;
            end
            RELEASE: begin
                if (rise) begin
                    state_d = ATTACK;
                    cnt_d   = '0;
                end else if (cnt_q == RELEASE_LAST) begin
                    cnt_d   = '0;
                    shift_d = (shift_q >= SHIFT_FULL) ? SHIFT_FULL : shift_q + 1'b1;
                    if (shift_d == SHIFT_FULL) state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign contrib_o = contrib_q;
    assign active_o  = active_q;

endmodule

// File: rtl/envelope_mixer.sv
// Polyphonic envelope-and-mix stage: per-voice envelopes, summing tree and output register.
// Define ENVELOPE_MIXER_SATURATE_EN to clip the sum instead of scaling it down.
module envelope_mixer
    import piano_pkg::*;
#(
    parameter int VOICES       = 3,
    parameter int SAMPLE_W     = 8,
    parameter int SHIFT_MAX    = DEFAULT_SHIFT_MAX,
    parameter int ATTACK_STEP  = DEFAULT_ATTACK_STEP,
    parameter int RELEASE_STEP = DEFAULT_RELEASE_STEP
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [VOICES-1:0]          gate,
    input  logic [VOICES*SAMPLE_W-1:0] voice_sample,
    output logic [SAMPLE_W-1:0]        wave,
    output logic [VOICES-1:0]          active
);

    localparam int LOG_V = $clog2(VOICES);
    localparam int SUM_W = SAMPLE_W + LOG_V;

    logic [VOICES-1:0][SAMPLE_W-1:0] contrib;
    logic [SUM_W-1:0]                sum_d;
    logic [SAMPLE_W-1:0]             wave_q, wave_d;

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        voice_envelope #(
            .SAMPLE_W    (SAMPLE_W),
            .SHIFT_MAX   (SHIFT_MAX),
            .ATTACK_STEP (ATTACK_STEP),
            .RELEASE_STEP(RELEASE_STEP)
        ) u_voice (
            .clk      (clk),
            .reset_n  (reset_n),
            .gate_i   (gate[v]),
            .sample_i (voice_sample[v*SAMPLE_W +: SAMPLE_W]),
            .contrib_o(contrib[v]),
            .active_o (active[v])
        );
    end

    always_comb begin
        sum_d = '0;
        for (int v = 0; v < VOICES; v++) begin
            sum_d = sum_d + SUM_W'(contrib[v]);
        end
    end

`ifdef ENVELOPE_MIXER_SATURATE_EN
    localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'({SAMPLE_W{1'b1}});

    always_comb begin
        wave_d = (sum_d > SAT_MAX) ? '1 : sum_d[SAMPLE_W-1:0];
    end
`else
    // Dividing by the next power of two at or above VOICES cannot overflow SAMPLE_W.
    always_comb begin
        wave_d = SAMPLE_W'(sum_d >> LOG_V);
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wave_q <= '0;
        else          wave_q <= wave_d;
    end

    assign wave = wave_q;

endmodule

// File: tb/tb_envelope_mixer.sv
// Directed bench for envelope_mixer: elapsed-time envelope model compared every cycle,
// plus hand-computed literal checkpoints; honours ENVELOPE_MIXER_SATURATE_EN.
module tb_envelope_mixer;

    localparam int NV   = 3;
    localparam int SW   = 8;
    localparam int SMAX = 8;
    localparam int AS   = 4;
    localparam int RS   = 8;

`ifdef ENVELOPE_MIXER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam int M_OFF = 0;
    localparam int M_ATK = 1;
    localparam int M_REL = 2;
    localparam int M_SUS = 3;

    logic              clk;
    logic              reset_n;
    logic [NV-1:0]     gate;
    logic [NV*SW-1:0]  voice_sample;
    logic [SW-1:0]     wave;
    logic [NV-1:0]     active;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    envelope_mixer #(
        .VOICES      (NV),
        .SAMPLE_W    (SW),
        .SHIFT_MAX   (SMAX),
        .ATTACK_STEP (AS),
        .RELEASE_STEP(RS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .gate        (gate),
        .voice_sample(voice_sample),
        .wave        (wave),
        .active      (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: each voice is a segment (attack or release) that started at some shift;
    // the shift is a closed-form function of clocks elapsed since the segment began.
    int            m_mode [NV];
    int            m_start[NV];
    int            m_seg  [NV];
    bit            m_gprev[NV];
    int            exp_contrib[NV];
    int            exp_wave;
    logic [NV-1:0] exp_active;

    function automatic int cur_shift(input int mode, input int start, input int seg);
        int s;
        case (mode)
            M_ATK:   begin s = start - seg / AS; if (s < 0) s = 0; end
            M_REL:   begin s = start + seg / RS; if (s > SMAX) s = SMAX; end
            M_SUS:   s = 0;
            default: s = SMAX;
        endcase
        return s;
    endfunction

    function automatic int mix(input int sum);
        if (SAT) return (sum > (1 << SW) - 1) ? (1 << SW) - 1 : sum;
        return sum >> $clog2(NV);
    endfunction

    function automatic int max1(input int x);
        return (x < 1) ? 1 : x;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        int  sum;
        int  s;
        bit  g;
        if (!reset_n) begin
            for (int v = 0; v < NV; v++) begin
                m_mode[v]      = M_OFF;
                m_start[v]     = SMAX;
                m_seg[v]       = 0;
                m_gprev[v]     = 1'b0;
                exp_contrib[v] = 0;
            end
            exp_wave   = 0;
            exp_active = '0;
        end else begin
            sum = 0;
            for (int v = 0; v < NV; v++) sum += exp_contrib[v];
            exp_wave = mix(sum);
            for (int v = 0; v < NV; v++) begin
                g = gate[v];
                s = cur_shift(m_mode[v], m_start[v], m_seg[v]);
                exp_active[v]  = (m_mode[v] != M_OFF);
                exp_contrib[v] = (m_mode[v] != M_OFF) ? (int'(voice_sample[v*SW +: SW]) >> s) : 0;
                if (m_mode[v] == M_OFF && g && !m_gprev[v]) begin
                    m_mode[v] = M_ATK; m_start[v] = SMAX; m_seg[v] = 0;
                end else if ((m_mode[v] == M_ATK || m_mode[v] == M_SUS) && !g && m_gprev[v]) begin
                    m_mode[v] = M_REL; m_start[v] = s; m_seg[v] = 0;
                end else if (m_mode[v] == M_REL && g && !m_gprev[v]) begin
                    m_mode[v] = M_ATK; m_start[v] = s; m_seg[v] = 0;
                end else if (m_mode[v] == M_ATK || m_mode[v] == M_REL) begin
                    m_seg[v]++;
                    if (m_mode[v] == M_ATK && m_seg[v] / AS >= max1(m_start[v]))
                        m_mode[v] = M_SUS;
                    else if (m_mode[v] == M_REL && m_seg[v] / RS >= max1(SMAX - m_start[v]))
                        m_mode[v] = M_OFF;
                end
                m_gprev[v] = g;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("wave_model", 32'(wave), 32'(exp_wave));
            check("active_model", 32'(active), 32'(exp_active));
        end
    end

    initial begin
        reset_n      = 1'b1;
        gate         = '0;
        voice_sample = '0;
        #1 reset_n = 1'b0;
        #1;
        check("reset_wave", 32'(wave), 32'h0);
        check("reset_active", 32'(active), 32'h0);
        cmp_en = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(1);

        // Full attack on voice 0 from silence, then full release.
        voice_sample[0 +: SW] = 8'hFF;
        gate[0] = 1'b1;
        tick(2);
        check("s1_active_on", 32'(active), 32'b001);
        check("s1_wave_start", 32'(wave), 32'h0);
        tick(32);
        check("s1_wave_last_step", 32'(wave), SAT ? 32'h7F : 32'h1F);
        tick(1);
        check("s1_wave_sustain", 32'(wave), SAT ? 32'hFF : 32'h3F);

        gate[0] = 1'b0;
        tick(65);
        check("s2_active_still", 32'(active), 32'b001);
        check("s2_wave_tail", 32'(wave), SAT ? 32'h1 : 32'h0);
        tick(1);
        check("s2_active_off", 32'(active), 32'b000);
        tick(1);
        check("s2_wave_zero", 32'(wave), 32'h0);
        tick(4);

        // All three voices sustained at 0xC0.
        voice_sample = {8'hC0, 8'hC0, 8'hC0};
        gate = 3'b111;
        tick(40);
        check("s3_wave_mix", 32'(wave), SAT ? 32'hFF : 32'h90);
        check("s3_active_all", 32'(active), 32'b111);
        gate = 3'b000;
        tick(80);
        check("s3_all_idle", 32'(active), 32'b000);

        // Release interrupted at shift 5 on voice 1, then retriggered.
        voice_sample[SW +: SW] = 8'hFF;
        gate[1] = 1'b1;
        tick(40);
        gate[1] = 1'b0;
        tick(44);
        gate[1] = 1'b1;
        tick(2);
        check("s4_no_silence", 32'(wave), SAT ? 32'h7 : 32'h1);
        tick(20);
        check("s4_last_step", 32'(wave), SAT ? 32'h7F : 32'h1F);
        tick(1);
        check("s4_sustain", 32'(wave), SAT ? 32'hFF : 32'h3F);
        gate[1] = 1'b0;
        tick(80);

        // One-clock gate pulse on voice 2.
        voice_sample[2*SW +: SW] = 8'h80;
        gate[2] = 1'b1;
        tick(1);
        gate[2] = 1'b0;
        tick(9);
        check("s5_active_pulse", 32'(active), 32'b100);
        check("s5_wave_silent", 32'(wave), 32'h0);
        tick(1);
        check("s5_active_off", 32'(active), 32'b000);
        tick(4);

        // Asynchronous reset mid-attack on voice 0, gate held through it.
        voice_sample[0 +: SW] = 8'hFF;
        gate[0] = 1'b1;
        tick(21);
        check("s6_wave_pre", 32'(wave), SAT ? 32'hF : 32'h3);
        #2 reset_n = 1'b0;
        #1;
        check("s6_wave_async", 32'(wave), 32'h0);
        check("s6_active_async", 32'(active), 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(34);
        check("s6_restart_step", 32'(wave), SAT ? 32'h7F : 32'h1F);
        tick(1);
        check("s6_restart_sustain", 32'(wave), SAT ? 32'hFF : 32'h3F);
        gate[0] = 1'b0;
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
